// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES-128 constants, S-box and key schedule state encoding
package aes_pkg;

   localparam int AES_NR = 10;

   localparam logic [0:9][7:0] RCON = 80'h01020408102040801b36;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Entry n sits at byte position n, so the first literal holds S(00)..S(0f).
   localparam logic [0:255][7:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TABLE[b];
   endfunction

   // Indices past the last expansion step never feed a stored key; return 0 there.
   function automatic logic [7:0] rcon_at(input logic [3:0] idx);
      return (idx < 4'd10) ? RCON[idx] : 8'h00;
   endfunction

endpackage

// File: rtl/key_expansion_if.sv
// rtl/key_expansion_if.sv - start/key request and round key handshake bundle
interface key_expansion_if;

   logic         start;
   logic [127:0] key_in;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         key_ready;
   logic         busy;
   logic         done;

   modport master (
      output start,
      output key_in,
      output key_ready,
      input  round_key,
      input  round_idx,
      input  key_valid,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  key_in,
      input  key_ready,
      output round_key,
      output round_idx,
      output key_valid,
      output busy,
      output done
   );

endinterface

// File: rtl/sub_word.sv
// rtl/sub_word.sv - four parallel S-box lookups on a 32-bit word
module sub_word
   import aes_pkg::*;
(
   input  logic [31:0] word,
   output logic [31:0] result
);

   genvar i;
   for (i = 0; i < 4; i++) begin : g_sbox
      assign result[8*i +: 8] = sbox(word[8*i +: 8]);
   end

endmodule

// File: rtl/key_expansion.sv
// rtl/key_expansion.sv - iterative AES-128 key schedule, one round key per transfer
module key_expansion
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDS = AES_NR
) (
   input logic             clk,
   input logic             rst,
   key_expansion_if.slave  bus
);

   state_t       state;
   logic [127:0] round_key;
   logic [3:0]   round_idx;
   logic         key_valid;
   logic         done;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  rot_w3;
   logic [31:0]  sub_w3;
   logic [31:0]  temp;
   logic [31:0]  n0, n1, n2, n3;
   logic         transfer;
   logic         last_key;

   assign {w0, w1, w2, w3} = round_key;
   assign rot_w3 = {w3[23:0], w3[31:24]};

   sub_word u_sub_word (
      .word   (rot_w3),
      .result (sub_w3)
   );

   // Next key is derived purely from the stored key, so key_ready never reaches an output.
   assign temp = sub_w3 ^ {rcon_at(round_idx), 24'h000000};
   assign n0   = w0 ^ temp;
   assign n1   = w1 ^ n0;
   assign n2   = w2 ^ n1;
   assign n3   = w3 ^ n2;

   assign transfer = key_valid & bus.key_ready;
   assign last_key = (round_idx == 4'(NUM_ROUNDS));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         round_key <= '0;
         round_idx <= '0;
         key_valid <= 1'b0;
         done      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state     <= RUN;
                  round_key <= bus.key_in;
                  round_idx <= '0;
                  key_valid <= 1'b1;
               end
            end
            RUN: begin
               if (transfer) begin
                  if (last_key) begin
                     state     <= DONE;
                     key_valid <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     round_key <= {n0, n1, n2, n3};
                     round_idx <= round_idx + 4'd1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               key_valid <= 1'b0;
               done      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.round_key = round_key;
   assign bus.round_idx = round_idx;
   assign bus.key_valid = key_valid;
   assign bus.busy      = (state != IDLE);
   assign bus.done      = done;

endmodule

// File: tb/tb_key_expansion.sv
// tb/tb_key_expansion.sv - directed checks of the AES-128 key schedule
module tb_key_expansion;

   localparam logic [127:0] A1_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   key_expansion_if bus_if ();

   key_expansion #(.NUM_ROUNDS(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   logic [127:0] a1_keys [0:10];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_key"},   bus_if.round_key,          128'h0);
      check({tag, "_idx"},   128'(bus_if.round_idx),    128'h0);
      check({tag, "_valid"}, 128'(bus_if.key_valid),    128'h0);
      check({tag, "_busy"},  128'(bus_if.busy),         128'h0);
      check({tag, "_done"},  128'(bus_if.done),         128'h0);
   endtask

   task automatic check_key(input string tag, input int k);
      check($sformatf("%s_idx%0d_idx", tag, k),   128'(bus_if.round_idx), 128'(k));
      check($sformatf("%s_idx%0d_key", tag, k),   bus_if.round_key,       a1_keys[k]);
      check($sformatf("%s_idx%0d_valid", tag, k), 128'(bus_if.key_valid), 128'h1);
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 40 && bus_if.busy; i++) tick();
      check({tag, "_idle"}, 128'(bus_if.busy), 128'h0);
   endtask

   // Full A.1 run; optional 3-cycle stall at idx4 and an ignored start at idx5.
   task automatic run_a1(input string tag, input bit stall, input bit poke);
      bus_if.key_in    = A1_KEY;
      bus_if.start     = 1'b1;
      bus_if.key_ready = 1'b1;
      tick();
      bus_if.start  = 1'b0;
      bus_if.key_in = '1;
      for (int k = 0; k <= 10; k++) begin
         check_key(tag, k);
         check($sformatf("%s_idx%0d_done", tag, k), 128'(bus_if.done), 128'h0);
         if (stall && k == 4) begin
            bus_if.key_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               tick();
               check_key({tag, "_stall"}, 4);
            end
            bus_if.key_ready = 1'b1;
         end
         if (poke && k == 5) begin
            bus_if.start  = 1'b1;
            bus_if.key_in = 128'h00112233445566778899aabbccddeeff;
         end
         tick();
         bus_if.start = 1'b0;
      end
      check({tag, "_done"},       128'(bus_if.done),      128'h1);
      check({tag, "_done_valid"}, 128'(bus_if.key_valid), 128'h0);
      check({tag, "_done_busy"},  128'(bus_if.busy),      128'h1);
      tick();
      check({tag, "_after_done"}, 128'(bus_if.done),      128'h0);
      check({tag, "_after_busy"}, 128'(bus_if.busy),      128'h0);
   endtask

   initial begin
      int t_done;
      int t_first;

      a1_keys[0]  = A1_KEY;
      a1_keys[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      a1_keys[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      a1_keys[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      a1_keys[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      a1_keys[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      a1_keys[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      a1_keys[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      a1_keys[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      a1_keys[9]  = 128'hac7766f319fadc2128d12941575c006e;
      a1_keys[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      rst              = 1'b1;
      bus_if.start     = 1'b0;
      bus_if.key_in    = '0;
      bus_if.key_ready = 1'b0;
      tick();
      tick();
      check_cleared("reset");
      rst = 1'b0;
      tick();

      run_a1("a1", 1'b0, 1'b0);

      bus_if.key_in    = '0;
      bus_if.start     = 1'b1;
      bus_if.key_ready = 1'b1;
      tick();
      bus_if.start = 1'b0;
      check("zero_idx0", bus_if.round_key, 128'h0);
      tick();
      check("zero_idx1", bus_if.round_key, 128'h62636363626363636263636362636363);
      tick();
      check("zero_idx2", bus_if.round_key, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
      wait_idle("zero");

      run_a1("stall", 1'b1, 1'b0);
      run_a1("poke", 1'b0, 1'b1);

      bus_if.key_in    = A1_KEY;
      bus_if.start     = 1'b1;
      bus_if.key_ready = 1'b1;
      tick();
      bus_if.start = 1'b0;
      for (int k = 0; k <= 6; k++) begin
         check_key("midrst", k);
         if (k < 6) tick();
      end
      rst = 1'b1;
      tick();
      check_cleared("midrst_cleared");
      rst = 1'b0;
      tick();
      run_a1("rerun", 1'b0, 1'b0);

      t_done  = -1;
      t_first = -1;
      bus_if.key_in    = A1_KEY;
      bus_if.start     = 1'b1;
      bus_if.key_ready = 1'b1;
      for (int i = 0; i < 40 && t_done < 0; i++) begin
         tick();
         if (bus_if.done) t_done = cyc;
      end
      for (int i = 0; i < 10 && t_first < 0; i++) begin
         tick();
         if (bus_if.key_valid && bus_if.round_idx == 4'd0) t_first = cyc;
      end
      check("b2b_done_seen", 128'(t_done >= 0), 128'h1);
      check("b2b_gap", 128'(t_first - t_done), 128'(2));
      check("b2b_idx0_key", bus_if.round_key, A1_KEY);
      bus_if.start = 1'b0;
      wait_idle("b2b");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
